// File: rtl/tag_unpacker.sv
// -----------------------------------------------------------------------------
// tag_unpacker
//
// Takes one packed vector of K tagged entries ({value, index}, index in the
// low bits) in a single transfer and streams the entries out one per
// handshake, entry 0 first, with out_last marking entry K-1. It undoes the
// index-tagging packer at the output of the top-K / sorting datapath.
//
// Optional feature (macro TAG_UNPACKER_INDEX_CHECK_EN):
//   when defined, every captured vector is checked for pairwise-distinct
//   index fields; a duplicate sets the sticky err flag the cycle after the
//   capture. When undefined, err is tied low and no check logic exists.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    packed vector, entry i at [TAG_W*(i+1)-1 : TAG_W*i]
//   in_valid   in_data valid
//   in_ready   unpacker can accept a vector
//   out_value  value field of the current entry
//   out_index  index field of the current entry
//   out_last   current entry is entry K-1
//   out_valid  out_* fields valid
//   out_ready  downstream accepts the current entry
//   busy       a vector is held (EMIT state); doubles as the FSM state view
//   err        sticky index-integrity error
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A source holds its data stable while valid is high and ready is
// low; valid never depends on ready. in_ready depends combinationally on
// out_ready so the last entry and the next vector can move in the same cycle.
// -----------------------------------------------------------------------------
module tag_unpacker #(
  parameter  int K     = 4,
  parameter  int SIZE  = 16,
  localparam int VAL_W = $clog2(SIZE),
  localparam int IDX_W = $clog2(K),
  localparam int TAG_W = VAL_W + IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TAG_W*K-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [VAL_W-1:0]   out_value,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               err
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic   [IDX_W-1:0]           cnt_q, cnt_d;
  logic   [K-1:0][TAG_W-1:0]    buf_q, buf_d;

  logic last_beat;
  logic capture;

  assign last_beat = (cnt_q == IDX_W'(K - 1));

  // The final entry leaving in this cycle frees the buffer for a new vector.
  assign in_ready  = (state_q == IDLE) | ((state_q == EMIT) & last_beat & out_ready);
  assign capture   = in_valid & in_ready;

  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign out_last  = (state_q == EMIT) & last_beat;
  assign out_value = buf_q[cnt_q][TAG_W-1:IDX_W];
  assign out_index = buf_q[cnt_q][IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          buf_d   = in_data;
          cnt_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (!last_beat) begin
            cnt_d = cnt_q + 1'b1;
          end else if (capture) begin
            // Back-to-back: reload without passing through IDLE.
            buf_d   = in_data;
            cnt_d   = '0;
            state_d = EMIT;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

`ifdef TAG_UNPACKER_INDEX_CHECK_EN
  logic [K-1:0] seen;
  logic         err_q, err_d;

  // Distinct indices cover every slot exactly once, so the OR of the one-hot
  // decodes is all ones only when no index repeats.
  always_comb begin
    seen = '0;
    for (int i = 0; i < K; i++) begin
      seen[in_data[TAG_W*i +: IDX_W]] = 1'b1;
    end
  end

  always_comb begin
    err_d = err_q | (capture & ~(&seen));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tag_unpacker.sv
// -----------------------------------------------------------------------------
// tb_tag_unpacker
//
// Bench for tag_unpacker with K=4, SIZE=16. A reference queue holds the
// entries still owed by the DUT as {last, value, index}; it is filled from
// the K slices of every accepted input vector and drained by every accepted
// output beat. Scenario tasks add their own targeted checks on top.
// Inputs change 1 time unit after the rising edge, outputs are sampled at
// +2 (scenario tasks) and +3 (scoreboard).
// -----------------------------------------------------------------------------
module tb_tag_unpacker;

  localparam int K     = 4;
  localparam int SIZE  = 16;
  localparam int VAL_W = $clog2(SIZE);
  localparam int IDX_W = $clog2(K);
  localparam int TAG_W = VAL_W + IDX_W;
  localparam int DW    = TAG_W * K;

  localparam logic [DW-1:0] V1 = {6'h3F, 6'h16, 6'h29, 6'h0C};
  localparam logic [DW-1:0] V3 = {6'h03, 6'h06, 6'h09, 6'h0C};
  localparam logic [DW-1:0] VD = {6'h3F, 6'h16, 6'h29, 6'h0D};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0]    in_data   = '0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [VAL_W-1:0] out_value;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             err;

  tag_unpacker #(.K(K), .SIZE(SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_value (out_value),
    .out_index (out_index),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err)
  );

  int errors = 0;
  int checks = 0;

  // scoreboard
  logic [TAG_W:0] exp_q[$];

  always @(posedge clk) begin
    logic [TAG_W:0] obs;
    logic [TAG_W:0] exp;
    #3;
    if (!rst && out_valid && out_ready) begin
      obs = {out_last, out_value, out_index};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_extra: got %h, expected no beat", obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          errors++;
          $display("FAIL beat: got {last,val,idx}=%h, expected %h", obs, exp);
        end
      end
    end
    if (!rst && in_valid && in_ready) begin
      for (int i = 0; i < K; i++) begin
        exp_q.push_back({(i == K - 1), in_data[TAG_W*i +: TAG_W]});
      end
    end
  end

  // driver
  task automatic cycle(input logic r, input logic iv, input logic [DW-1:0] d,
                       input logic ordy);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if ({out_valid, busy, err, out_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs: got {valid,busy,err,last}=%b, expected 0000",
               {out_valid, busy, err, out_last});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int nv = 0;
    cycle(1'b0, 1'b1, V1, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_in_ready: got %b, expected 1", in_ready);
    end
    for (int c = 1; c <= 7; c++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      if (c == 1) begin
        checks++;
        if ({out_valid, out_value, out_index} !== {1'b1, 4'h3, 2'd0}) begin
          errors++;
          $display("FAIL basic_first_beat: got {v,val,idx}=%h, expected 1,3,0",
                   {out_valid, out_value, out_index});
        end
      end
      if (out_valid) begin
        nv++;
        checks++;
        if (out_last !== (nv == 4)) begin
          errors++;
          $display("FAIL basic_last: beat %0d got %b", nv, out_last);
        end
      end
    end
    checks++;
    if (nv != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_count: got %0d beats (%0d owed), expected 4 (0)",
               nv, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic stall;
    cycle(1'b0, 1'b1, V1, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      stall = (c >= 2 && c <= 4);
      // in_valid during the stall must be ignored
      cycle(1'b0, stall, V3, !stall);
      if (stall) begin
        checks++;
        if ({out_valid, out_value, out_index, in_ready} !== {1'b1, 4'hA, 2'd1, 1'b0}) begin
          errors++;
          $display("FAIL stall_hold: c=%0d got {v,val,idx,in_rdy}=%h, expected 1,A,1,0",
                   c, {out_valid, out_value, out_index, in_ready});
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_done: got out_valid=%b owed=%0d, expected 0 0",
               out_valid, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0;
    int nv    = 0;
    int first = -1;
    int lastc = -1;
    logic iv;
    for (int c = 0; c < 14; c++) begin
      iv = (n_acc < 2);
      cycle(1'b0, iv, (n_acc == 0) ? V1 : V3, 1'b1);
      if (out_valid) begin
        nv++;
        if (first < 0) first = c;
        lastc = c;
        if (nv == 4) begin
          checks++;
          if ({out_last, in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_ready_on_last: got {last,in_rdy}=%b, expected 11",
                     {out_last, in_ready});
          end
        end
        if (nv == 5) begin
          checks++;
          if ({out_value, out_index} !== {4'h3, 2'd0}) begin
            errors++;
            $display("FAIL b2b_second_first: got %h, expected (3,0)",
                     {out_value, out_index});
          end
        end
      end
      if (iv && in_ready) n_acc++;
    end
    checks++;
    if (nv != 8 || (lastc - first) != 7) begin
      errors++;
      $display("FAIL b2b_no_bubble: got %0d beats over %0d cycles, expected 8 over 8",
               nv, lastc - first + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_last = 1'b0;
    int   nv       = 0;
    cycle(1'b0, 1'b1, V1, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    // beat 2 is on the outputs now; reset at the coming edge
    cycle(1'b1, 1'b0, '0, 1'b1);
    exp_q.delete();
    cycle(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_idle: got {valid,busy}=%b, expected 00", {out_valid, busy});
    end
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      if (out_last) saw_last = 1'b1;
    end
    checks++;
    if (saw_last !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_last: got out_last after reset, expected none");
    end
    cycle(1'b0, 1'b1, V3, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      if (out_valid) nv++;
      if (c == 1) begin
        checks++;
        if ({out_valid, out_value, out_index} !== {1'b1, 4'h3, 2'd0}) begin
          errors++;
          $display("FAIL rstmid_restart: got {v,val,idx}=%h, expected 1,3,0",
                   {out_valid, out_value, out_index});
        end
      end
    end
    checks++;
    if (nv != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_count: got %0d beats (%0d owed), expected 4 (0)",
               nv, exp_q.size());
    end
  endtask

  task automatic test_index_check();
    logic exp_err;
`ifdef TAG_UNPACKER_INDEX_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    cycle(1'b0, 1'b1, VD, 1'b1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL idx_before: got err=%b, expected 0", err);
    end
    for (int c = 1; c <= 6; c++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (err !== exp_err) begin
        errors++;
        $display("FAIL idx_err: c=%0d got err=%b, expected %b", c, err, exp_err);
      end
      if (c == 1) begin
        checks++;
        if ({out_value, out_index} !== {4'h3, 2'd1}) begin
          errors++;
          $display("FAIL idx_first_beat: got %h, expected (3,1)", {out_value, out_index});
        end
      end
    end
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL idx_clear: got err=%b after reset, expected 0", err);
    end
  endtask

  task automatic test_random();
    logic          iv   = 1'b0;
    logic [DW-1:0] d    = '0;
    logic          ordy;
    logic          p_stall = 1'b0;
    logic [TAG_W:0] p_out  = '0;
    int            r;
    for (int c = 0; c < 400; c++) begin
      if (!iv) begin
        iv = ($urandom_range(0, 3) != 0);
        r  = $urandom_range(0, K - 1);
        for (int i = 0; i < K; i++) begin
          d[TAG_W*i +: TAG_W] = {VAL_W'($urandom_range(0, SIZE - 1)),
                                 IDX_W'((i + r) % K)};
        end
      end
      ordy = ($urandom_range(0, 3) != 0);
      cycle(1'b0, iv, d, ordy);
      if (p_stall) begin
        checks++;
        if ({out_valid, out_last, out_value, out_index} !== {1'b1, p_out}) begin
          errors++;
          $display("FAIL rand_stall: got %h, expected held %h",
                   {out_valid, out_last, out_value, out_index}, {1'b1, p_out});
        end
      end
      p_stall = out_valid && !out_ready;
      p_out   = {out_last, out_value, out_index};
      if (iv && in_ready) iv = 1'b0;
    end
    for (int c = 0; c < 12; c++) cycle(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got out_valid=%b owed=%0d, expected 0 0",
               out_valid, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_index_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
